// File: rtl/cam_timing_seq.sv
// cam_timing_seq
// Camera-style video timing generator: produces pclk, href, vsync, a pixel
// strobe and x/y pixel coordinates for single or free-running frames.
// Optional test pattern output pix_data is enabled with the macro
// CAM_TIMING_SEQ_PATTERN_EN.
module cam_timing_seq #(
   parameter int PIX_DIV  = 4,
   parameter int H_ACTIVE = 640,
   parameter int H_BLANK  = 144,
   parameter int V_SYNC   = 3,
   parameter int V_BACK   = 17,
   parameter int V_LINES  = 480,
   parameter int V_FRONT  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        stop,
   input  logic        continuous,
   output logic        pclk,
   output logic        href,
   output logic        vsync,
   output logic        pix_tick,
   output logic [15:0] pix_x,
   output logic [15:0] pix_y,
   output logic        frame_done,
   output logic        busy
`ifdef CAM_TIMING_SEQ_PATTERN_EN
   ,
   output logic [7:0]  pix_data
`endif
);

   localparam int H_TOTAL = H_ACTIVE + H_BLANK;
   localparam int PW      = $clog2(PIX_DIV);

   localparam logic [PW-1:0] PIX_LAST = PW'(PIX_DIV - 1);
   localparam logic [PW-1:0] PIX_HALF = PW'(PIX_DIV / 2);
   localparam logic [15:0]   X_LAST   = 16'(H_TOTAL - 1);
   localparam logic [15:0]   X_ACTIVE = 16'(H_ACTIVE);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      VSYNC  = 3'd1,
      VBACK  = 3'd2,
      ACTIVE = 3'd3,
      VFRONT = 3'd4
   } state_t;

   state_t         state;
   state_t         next_state;
   logic [PW-1:0]  pix_cnt;
   logic [15:0]    line_cnt;
   logic [15:0]    line_limit;
   logic           stop_pending;
   logic           period_end;
   logic           line_end;
   logic           last_line;
   logic           frame_end;

   // Line budget of the current vertical region, used to find its last line
   always_comb begin
      line_limit = 16'd1;
      case (state)
         VSYNC:   line_limit = 16'(V_SYNC);
         VBACK:   line_limit = 16'(V_BACK);
         ACTIVE:  line_limit = 16'(V_LINES);
         VFRONT:  line_limit = 16'(V_FRONT);
         default: line_limit = 16'd1;
      endcase
   end

   // Timing event decode: end of pixel period, end of line, end of frame
   always_comb begin
      period_end = (state != IDLE) && (pix_cnt == '0);
      line_end   = period_end && (pix_x == X_LAST);
      last_line  = (line_cnt == (line_limit - 16'd1));
      frame_end  = (state == VFRONT) && line_end && last_line;
   end

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state logic: regions only change on the last line's final pixel;
   // a stop arriving on the exit cycle itself still forces a return to IDLE
   always_comb begin
      next_state = state;
      case (state)
         IDLE: begin
            if (start) next_state = VSYNC;
         end
         VSYNC: begin
            if (line_end && last_line) next_state = VBACK;
         end
         VBACK: begin
            if (line_end && last_line) next_state = ACTIVE;
         end
         ACTIVE: begin
            if (line_end && last_line) next_state = VFRONT;
         end
         VFRONT: begin
            if (frame_end) begin
               if (continuous && !stop_pending && !stop) next_state = VSYNC;
               else                                    next_state = IDLE;
            end
         end
         default: next_state = IDLE;
      endcase
   end

   // Output decode from the registered state and counters
   always_comb begin
      busy     = (state != IDLE);
      vsync    = (state == VSYNC);
      href     = (state == ACTIVE) && (pix_x < X_ACTIVE);
      pix_tick = busy && (pix_cnt == PIX_LAST);
      pclk     = busy && (pix_cnt >= PIX_HALF);
   end

   // Pixel, line and row counters plus the deferred-stop flag
   always_ff @(posedge clk) begin
      if (reset) begin
         pix_cnt      <= '0;
         pix_x        <= '0;
         pix_y        <= '0;
         line_cnt     <= '0;
         stop_pending <= 1'b0;
         frame_done   <= 1'b0;
      end else begin
         frame_done <= frame_end;

         if (state == IDLE) begin
            pix_cnt  <= start ? PIX_LAST : '0;
            pix_x    <= '0;
            pix_y    <= '0;
            line_cnt <= '0;
         end else begin
            pix_cnt <= period_end ? PIX_LAST : (pix_cnt - 1'b1);

            if (period_end) begin
               pix_x <= line_end ? 16'd0 : (pix_x + 16'd1);
            end

            if (line_end) begin
               line_cnt <= last_line ? 16'd0 : (line_cnt + 16'd1);
               if (state == ACTIVE) begin
                  pix_y <= last_line ? 16'd0 : (pix_y + 16'd1);
               end
            end
         end

         if ((state != IDLE) && stop) begin
            stop_pending <= 1'b1;
         end
         if (next_state == IDLE) begin
            stop_pending <= 1'b0;
         end
      end
   end

`ifdef CAM_TIMING_SEQ_PATTERN_EN
   // Diagonal XOR test pattern, present only while the line is valid
   always_comb begin
      pix_data = href ? (pix_x[7:0] ^ pix_y[7:0]) : 8'd0;
   end
`endif

endmodule
